i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 34 +++
 rtl/i2c_target.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } i2c_state_e;

  localparam logic       I2C_ACK              = 1'b0;
  localparam logic       I2C_NACK             = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h21;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk_i domain and flags START, STOP and SCL edges.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synchronized value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit auto-incrementing register pointer and a small flop register file.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_DEV_ADDR,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  output i2c_state_e dbg_state_o
);

  localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] ACK_CNT = 4'd8;

  logic sda_s, start, stop, scl_rise, scl_fall;

  i2c_bus_sync u_sync (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .start_o    (start),
    .stop_o     (stop),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       oe_q, oe_d;
  logic       commit;
  logic       wr_valid_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [7:0] regs [NUM_REGS];

  logic [7:0]       ptr_next;
  logic             cur_in_range, nxt_in_range;
  logic [IDX_W-1:0] cur_idx, nxt_idx;
  logic [7:0]       rd_cur, rd_nxt;
  logic             bit_in, byte_done;

  assign ptr_next     = ptr_q + 8'd1;
  assign cur_in_range = ({1'b0, ptr_q} < 9'(NUM_REGS));
  assign nxt_in_range = ({1'b0, ptr_next} < 9'(NUM_REGS));
  assign cur_idx      = ptr_q[IDX_W-1:0];
  assign nxt_idx      = ptr_next[IDX_W-1:0];
  assign rd_cur       = cur_in_range ? regs[cur_idx] : 8'h00;
  assign rd_nxt       = nxt_in_range ? regs[nxt_idx] : 8'h00;
  assign bit_in       = scl_rise && (bit_cnt_q != ACK_CNT);
  assign byte_done    = scl_fall && (bit_cnt_q == ACK_CNT);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      mack_q    <= I2C_NACK;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      oe_q      <= oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    oe_d      = oe_q;
    commit    = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_SUB, S_WDATA: begin
          if (bit_in) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            oe_d      = 1'b1;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = shift_q[0];
              end else begin
                state_d = S_WAIT_STOP;
                oe_d    = 1'b0;
              end
            end else if (state_q == S_SUB) begin
              ptr_d   = shift_q;
              state_d = S_SUB_ACK;
            end else begin
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = S_RDATA;
              tx_d    = rd_cur;
              oe_d    = ~rd_cur[7];
            end else begin
              state_d = S_SUB;
              oe_d    = 1'b0;
            end
          end
        end
        S_SUB_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            oe_d    = 1'b0;
          end
        end
        S_WDATA_ACK: begin
          // The byte is committed only once its ACK slot has fully ended.
          if (scl_fall) begin
            commit  = cur_in_range;
            ptr_d   = ptr_next;
            state_d = S_WDATA;
            oe_d    = 1'b0;
          end
        end
        S_RDATA: begin
          if (bit_in) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            state_d   = S_RDATA_ACK;
            oe_d      = 1'b0;
          end else if (scl_fall) begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            // Every byte sent advances the pointer, including the NACKed last one.
            ptr_d = ptr_next;
            if (mack_q == I2C_ACK) begin
              state_d = S_RDATA;
              tx_d    = rd_nxt;
              oe_d    = ~rd_nxt[7];
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q     <= ptr_q;
        wr_data_q     <= shift_q;
        regs[cur_idx] <= shift_q;
      end
    end
  end

  assign sda_oe_o    = oe_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
